adc_sampler_avg: RTL

ADC_SAMPLER_AVG -- requirements
Module: adc_sampler_avg

---
 rtl/sensor_pkg.sv | 32 +++
 rtl/adc_ch_accum.sv | 52 +++++
 rtl/adc_sampler_avg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the ADC sampling / averaging block:
//   - state_t      : sequencer states (IDLE / ACCUM / PUBLISH)
//   - acc_width    : accumulator width that cannot overflow over one window
//   - presc_width  : width of the sample-tick prescaler counter
//   - cnt_width    : width of the per-window sample counter (at least 1 bit)
// -----------------------------------------------------------------------------
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    // Summing 2^avg_log2 samples of data_w bits needs avg_log2 extra bits.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    function automatic int presc_width(input int sample_div);
        return (sample_div > 1) ? $clog2(sample_div) : 1;
    endfunction

    // With no averaging the counter is never more than 0, but a vector
    // still needs one bit.
    function automatic int cnt_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// -----------------------------------------------------------------------------
// adc_ch_accum
// One channel's window accumulator with averaging shift and alarm compare.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - discard the running sum (window abandoned or just published)
//   add       - add sample into the running sum this cycle
//   sample    - channel sample (DATA_W)
//   thr_hi    - alarm threshold (DATA_W)
//   avg       - running sum >> AVG_LOG2, truncated (combinational)
//   above     - avg strictly greater than thr_hi (combinational)
// -----------------------------------------------------------------------------
module adc_ch_accum
    import sensor_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_hi,
    output logic [DATA_W-1:0] avg,
    output logic              above
);

    localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);

    logic [ACC_W-1:0] acc_r;

    // Running window sum; clear wins over add.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (add) begin
            acc_r <= acc_r + ACC_W'(sample);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Average by shifting out the window size, then strict threshold compare.
    always_comb begin
        avg   = DATA_W'(acc_r >> AVG_LOG2);
        above = (avg > thr_hi);
    end

endmodule

// File: rtl/adc_sampler_avg.sv
// -----------------------------------------------------------------------------
// adc_sampler_avg
// Samples NUM_CH sensor channels every SAMPLE_DIV clocks while enabled,
// averages 2^AVG_LOG2 samples per channel and publishes the result through a
// valid/ready output with per-channel threshold alarms and a sticky overrun.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - sampling enable; low discards the partial window
//   raw_in     - NUM_CH samples, channel 0 in the LSBs
//   thr_hi     - alarm threshold shared by all channels
//   ovr_clr    - clears the sticky overrun flag
//   out_ready  - consumer accepts avg_out
//   avg_out    - registered averages, channel 0 in the LSBs
//   out_valid  - avg_out holds an unconsumed result
//   alarm      - bit i set when channel i average exceeded thr_hi at publish
//   overrun    - sticky: a completed window was dropped
// -----------------------------------------------------------------------------
module adc_sampler_avg
    import sensor_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int AVG_LOG2   = 2,
    parameter int SAMPLE_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] raw_in,
    input  logic [DATA_W-1:0]        thr_hi,
    input  logic                     ovr_clr,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] avg_out,
    output logic                     out_valid,
    output logic [NUM_CH-1:0]        alarm,
    output logic                     overrun
);

    localparam int PRESC_W = presc_width(SAMPLE_DIV);
    localparam int CNT_W   = cnt_width(AVG_LOG2);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

    state_t                     state_r;
    state_t                     state_nx_s;
    logic [PRESC_W-1:0]         presc_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       tick_s;
    logic                       add_s;
    logic                       publish_s;
    logic                       clr_s;
    logic                       win_done_s;
    logic                       load_s;
    logic                       drop_s;
    logic [NUM_CH*DATA_W-1:0]   avg_s;
    logic [NUM_CH-1:0]          above_s;
    logic [NUM_CH*DATA_W-1:0]   avg_out_r;
    logic                       out_valid_r;
    logic [NUM_CH-1:0]          alarm_r;
    logic                       overrun_r;

    assign tick_s     = en && (presc_r == PRESC_LAST);
    // With AVG_LOG2 = 0 CNT_LAST is 0, so every tick completes a window.
    assign win_done_s = add_s && (cnt_r == CNT_LAST);

    // Sample-tick prescaler, held at 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (!en) begin
            presc_r <= '0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Samples taken in the current window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (add_s) begin
            cnt_r <= win_done_s ? '0 : (cnt_r + CNT_W'(1));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequencer next state; dropping en always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        if (!en) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nx_s = ST_ACCUM;
                ST_ACCUM:   state_nx_s = win_done_s ? ST_PUBLISH : ST_ACCUM;
                ST_PUBLISH: state_nx_s = ST_ACCUM;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer outputs and publish handshake decisions.
    always_comb begin
        add_s     = 1'b0;
        publish_s = 1'b0;
        case (state_r)
            ST_ACCUM:   add_s     = tick_s;
            ST_PUBLISH: publish_s = 1'b1;
            default: begin
                add_s     = 1'b0;
                publish_s = 1'b0;
            end
        endcase
        clr_s  = !en || publish_s;
        load_s = publish_s && (!out_valid_r || out_ready);
        drop_s = publish_s && out_valid_r && !out_ready;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        adc_ch_accum #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_accum (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr_s),
            .add    (add_s),
            .sample (raw_in[ch*DATA_W +: DATA_W]),
            .thr_hi (thr_hi),
            .avg    (avg_s[ch*DATA_W +: DATA_W]),
            .above  (above_s[ch])
        );
    end

    // Published result and alarms; only a load may change them.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_out_r <= '0;
            alarm_r   <= '0;
        end else if (load_s) begin
            avg_out_r <= avg_s;
            alarm_r   <= above_s;
        end else begin
            avg_out_r <= avg_out_r;
            alarm_r   <= alarm_r;
        end
    end

    // Output valid: a load in the same cycle as a consume keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky overrun; a new drop beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign avg_out   = avg_out_r;
    assign out_valid = out_valid_r;
    assign alarm     = alarm_r;
    assign overrun   = overrun_r;

endmodule
